systolic_feed_ctrl: RTL
=======================

Name: systolic_feed_ctrl

Overview:
- Parametrised successor of the per-row A/B operand control chains.
- Owns a complete operand-feed pass for one systolic-array edge (A rows or B columns). From a single start pulse it:
  - generates per-lane SRAM read enables and addresses, skewed one cycle per lane;
  - aligns returning SRAM data into PE-facing valid/data/last streams;
  - reports completion.
- Mode (datatype × tile shape) selects the K-step count; illegal modes are rejected.
- One instance feeds A and one feeds B. Lane count, widths and SRAM latency are parameters.

Parameters:
- LANES, 8, number of skewed lanes (array rows or columns).
- ADDR_W, 32, SRAM address width.
- DATA_W, 32, operand word width per lane.
- SRAM_LAT, 1, SRAM read latency in cycles (≥1).
- STEP_W, 6, step-counter width (must hold max steps = 32).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- abort  in  1  synchronous flush; return to IDLE without done.
- cfg_mode  in  params::addrgen_t  {datatype, rc}; latched at start.
- cfg_base  in  ADDR_W  lane-0 address of step 0.
- cfg_k_stride  in  ADDR_W  address increment per K step.
- cfg_lane_stride  in  ADDR_W  address offset between adjacent lanes.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse when start carries an illegal mode.
- sram_rd_en  out  [LANES]  per-lane read enable.
- sram_rd_addr  out  [LANES][ADDR_W]  per-lane read address.
- sram_rd_data  in  [LANES][DATA_W]  per-lane read data, SRAM_LAT after rd_en.
- pe_valid  out  [LANES]  lane data valid toward PE.
- pe_data  out  [LANES][DATA_W]  lane operand (sram_rd_data passed through combinationally).
- pe_last  out  [LANES]  marks the final K step on the lane.

Behaviour:
- Reset (async):
  - FSM=IDLE; all chains, counters and latched config cleared.
  - busy, done, cfg_err, sram_rd_en, pe_valid, pe_last = 0; sram_rd_addr = 0.
- Step count N from the mode:
  - INT8: rc 00→8, 01→16, 10→32.
  - INT4: rc 00→4, 01→8, 10→16.
  - rc 11 or unknown datatype is illegal.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE, start & legal mode: latch config, step=0, addr_acc=cfg_base, go ISSUE, busy=1 next cycle.
  - IDLE, start & illegal mode: cfg_err=1 for one cycle, stay IDLE.
  - ISSUE, per cycle:
    - lane-0 chain input: en=1, addr=addr_acc, last=(step==N-1);
    - step++ and addr_acc += k_stride (wraps mod 2^ADDR_W);
    - after step N-1 go DRAIN.
  - DRAIN: wait until every skew stage and valid pipeline is empty (LANES-1+SRAM_LAT cycles), then go DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Skew chain:
  - Lane i carries {en, addr, last} delayed exactly i cycles from lane 0.
  - sram_rd_en[i] = chain en[i].
  - sram_rd_addr[i] = chain addr[i] + i·lane_stride. Lane offsets are precomputed into registers at start; no multiplier on the per-cycle path.
- Data alignment:
  - pe_valid[i] and pe_last[i] are sram_rd_en[i] and chain last[i] delayed SRAM_LAT cycles.
  - pe_data[i] = sram_rd_data[i].
- Timing: with cycle 1 = first cycle after the start edge:
  - sram_rd_en[i] is high for cycles 1+i..N+i;
  - pe_valid[i] is high for cycles 1+i+SRAM_LAT..N+i+SRAM_LAT;
  - done is asserted at cycle N+LANES+SRAM_LAT.
- start while busy is ignored; no queueing.
- abort has priority over start in the same cycle. On abort, the next cycle has:
  - all chains cleared, FSM=IDLE, busy=0;
  - no done and no further rd_en.
- Async reset mid-pass: all outputs drop immediately; no done.
- Config inputs are don't-care outside the start cycle.

Decomposition:
- params package holds:
  - dtype_e (INT8, INT4) and addrgen_t {datatype, rc[1:0]};
  - fsm state enum;
  - function mode_steps(addrgen_t) returning N and a legal flag.
- Sub-module lane_skew_stage: one-cycle register stage of {en, addr, last} with async reset and sync flush. It is instantiated LANES-1 times in a generate loop.

Test Plan:
- LANES=8, SRAM_LAT=1, INT8 rc=00, base=0x100, k_stride=4, lane_stride=0x40, start → expected:
  - sram_rd_addr[0] = 0x100..0x11C in cycles 1..8;
  - lane 3 first read at cycle 4, addr 0x1C0;
  - pe_last[7] at cycle 16; done at cycle 17.
- INT4 rc=10 → 16 steps per lane; done at cycle 25; busy high cycles 1..24.
- Mode rc=11 with start → cfg_err pulses once; busy, rd_en and done stay 0.
- base=0xFFFFFFF8, k_stride=4, INT8 rc=00 → lane-0 addresses wrap to 0x0, 0x4, ...
- abort asserted in cycle 5 → all sram_rd_en and pe_valid are 0 from cycle 6; no done; a new start in cycle 7 runs normally.
- Async rst pulse mid-ISSUE → outputs clear without waiting for a clock edge; start held during busy → ignored; only one done.

Source files
------------

// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types for the systolic operand-feed controller.
//   dtype_e      : operand datatype (INT8, INT4); other encodings are illegal
//   addrgen_t    : {datatype, rc} mode word latched at start
//   feed_state_e : controller FSM states
//   mode_steps() : maps a mode to its K-step count plus a legal flag
package systolic_feed_ctrl_pkg;

  typedef enum logic [1:0] {
    DT_INT8 = 2'b00,
    DT_INT4 = 2'b01
  } dtype_e;

  typedef struct packed {
    dtype_e     datatype;
    logic [1:0] rc;
  } addrgen_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

  localparam int MODE_STEP_W = 6;

  typedef struct packed {
    logic                   legal;
    logic [MODE_STEP_W-1:0] steps;
  } mode_info_t;

  function automatic mode_info_t mode_steps(input addrgen_t mode);
    mode_info_t info;
    info.legal = 1'b1;
    info.steps = '0;
    case (mode.datatype)
      DT_INT8: begin
        case (mode.rc)
          2'b00:   info.steps = 6'd8;
          2'b01:   info.steps = 6'd16;
          2'b10:   info.steps = 6'd32;
          default: info.legal = 1'b0;
        endcase
      end
      DT_INT4: begin
        case (mode.rc)
          2'b00:   info.steps = 6'd4;
          2'b01:   info.steps = 6'd8;
          2'b10:   info.steps = 6'd16;
          default: info.legal = 1'b0;
        endcase
      end
      default: info.legal = 1'b0;
    endcase
    if (!info.legal) info.steps = '0;
    return info;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_lane_skew_stage.sv
// One register stage of the lane skew chain: delays {en, addr, last} by one
// cycle. Async reset and synchronous flush both clear the stage.
//   clk, rst          : clock, async active-high reset
//   flush             : synchronous clear
//   in_en/addr/last   : stage input from the previous lane
//   out_en/addr/last  : stage output toward the next lane
module lane_skew_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_en,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  output logic              out_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en   <= 1'b0;
      out_addr <= '0;
      out_last <= 1'b0;
    end else if (flush) begin
      out_en   <= 1'b0;
      out_addr <= '0;
      out_last <= 1'b0;
    end else begin
      out_en   <= in_en;
      out_addr <= in_addr;
      out_last <= in_last;
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Operand-feed controller for one systolic-array edge. A start pulse runs a
// full pass: skewed per-lane SRAM reads, SRAM_LAT-aligned PE valid/last,
// and a done pulse.
//   start/abort           : begin a pass (IDLE only) / synchronous flush
//   cfg_*                 : mode, base, K stride, lane stride (start cycle)
//   busy/done/cfg_err     : status
//   sram_rd_en/addr/data  : per-lane SRAM read port
//   pe_valid/data/last    : per-lane PE-facing stream
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | lane 0 issues one read per cycle for N steps
// DRAIN | skew chain and latency pipeline emptying
// DONE  | one-cycle done pulse
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SRAM_LAT = 1,
  parameter int STEP_W   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  addrgen_t                      cfg_mode,
  input  logic [ADDR_W-1:0]             cfg_base,
  input  logic [ADDR_W-1:0]             cfg_k_stride,
  input  logic [ADDR_W-1:0]             cfg_lane_stride,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic [LANES-1:0]              sram_rd_en,
  output logic [LANES-1:0][ADDR_W-1:0]  sram_rd_addr,
  input  logic [LANES-1:0][DATA_W-1:0]  sram_rd_data,
  output logic [LANES-1:0]              pe_valid,
  output logic [LANES-1:0][DATA_W-1:0]  pe_data,
  output logic [LANES-1:0]              pe_last
);

  localparam int DRAIN_CYC = LANES - 1 + SRAM_LAT;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);

  feed_state_e        state_q, state_d;
  mode_info_t         mode_info;
  logic               accept, reject, last_step;
  logic [STEP_W-1:0]  step_q, n_q;
  logic [ADDR_W-1:0]  addr_acc_q, k_stride_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               cfg_err_q;
  logic [ADDR_W-1:0]  off_q [LANES];
  logic [ADDR_W-1:0]  off_d [LANES];

  logic [LANES-1:0]   lane_en, lane_last;
  logic [ADDR_W-1:0]  lane_addr [LANES];

  logic [LANES-1:0]   vpipe_q [SRAM_LAT];
  logic [LANES-1:0]   lpipe_q [SRAM_LAT];

  assign mode_info = mode_steps(cfg_mode);
  assign last_step = (step_q == n_q - STEP_ONE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (mode_info.legal) begin
            accept  = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_ISSUE: if (last_step) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Lane offsets i*lane_stride are built once at start by an adder chain so
  // the per-cycle address path is a single add per lane.
  always_comb begin
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      off_d[i] = acc;
      acc      = acc + cfg_lane_stride;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q     <= '0;
      n_q        <= '0;
      addr_acc_q <= '0;
      k_stride_q <= '0;
      drain_q    <= '0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) off_q[i] <= '0;
    end else begin
      cfg_err_q <= reject;
      if (accept) begin
        step_q     <= '0;
        n_q        <= STEP_W'(mode_info.steps);
        addr_acc_q <= cfg_base;
        k_stride_q <= cfg_k_stride;
        for (int i = 0; i < LANES; i++) off_q[i] <= off_d[i];
      end else if (state_q == ST_ISSUE) begin
        step_q     <= step_q + STEP_ONE;
        addr_acc_q <= addr_acc_q + k_stride_q;
      end
      if (state_q == ST_ISSUE && last_step) begin
        drain_q <= DRAIN_LOAD;
      end else if (state_q == ST_DRAIN && drain_q != '0) begin
        drain_q <= drain_q - DRAIN_ONE;
      end
    end
  end

  // Lane 0 is the combinational head of the chain; lanes 1.. are registered.
  assign lane_en[0]   = (state_q == ST_ISSUE);
  assign lane_addr[0] = lane_en[0] ? addr_acc_q : '0;
  assign lane_last[0] = lane_en[0] & last_step;

  for (genvar g = 1; g < LANES; g++) begin : g_skew
    lane_skew_stage #(.ADDR_W(ADDR_W)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (abort),
      .in_en    (lane_en[g-1]),
      .in_addr  (lane_addr[g-1]),
      .in_last  (lane_last[g-1]),
      .out_en   (lane_en[g]),
      .out_addr (lane_addr[g]),
      .out_last (lane_last[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SRAM_LAT; k++) begin
        vpipe_q[k] <= '0;
        lpipe_q[k] <= '0;
      end
    end else if (abort) begin
      for (int k = 0; k < SRAM_LAT; k++) begin
        vpipe_q[k] <= '0;
        lpipe_q[k] <= '0;
      end
    end else begin
      vpipe_q[0] <= lane_en;
      lpipe_q[0] <= lane_last;
      for (int k = 1; k < SRAM_LAT; k++) begin
        vpipe_q[k] <= vpipe_q[k-1];
        lpipe_q[k] <= lpipe_q[k-1];
      end
    end
  end

  // Idle lanes drive address 0 rather than their bare lane offset.
  always_comb begin
    sram_rd_addr = '0;
    for (int i = 0; i < LANES; i++) begin
      sram_rd_addr[i] = lane_en[i] ? (lane_addr[i] + off_q[i]) : '0;
    end
  end

  assign sram_rd_en = lane_en;
  assign pe_valid   = vpipe_q[SRAM_LAT-1];
  assign pe_last    = lpipe_q[SRAM_LAT-1];
  assign pe_data    = sram_rd_data;
  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign cfg_err    = cfg_err_q;

endmodule
